// File: rtl/imm_ext_pkg.sv
// Shared types for the registered immediate-extension unit.
package imm_ext_pkg;

    localparam int MODE_W = 2;

    // Extension mode; the encoding is visible to the decoder, so it is fixed.
    typedef enum logic [MODE_W-1:0] {
        EXT_SEXT   = 2'd0,
        EXT_ZEXT   = 2'd1,
        EXT_UPPER  = 2'd2,
        EXT_BRANCH = 2'd3
    } ext_mode_e;

    // Occupancy of the output register plus skid register.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: IN_W-bit field to OUT_W-bit operand.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]   i_imm,
    input  logic [MODE_W-1:0] i_mode,
    output logic [OUT_W-1:0]  o_result
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_upper;
    logic [OUT_W-1:0] w_branch;

    assign w_sext   = {{PAD_W{i_imm[IN_W-1]}}, i_imm};
    assign w_zext   = {{PAD_W{1'b0}}, i_imm};
    assign w_upper  = {i_imm, {PAD_W{1'b0}}};
    // Word offset to byte offset; the two sign bits shifted out are dropped.
    assign w_branch = {w_sext[OUT_W-3:0], 2'b00};

    // Select the extension requested for this transaction.
    always_comb begin
        o_result = w_sext;
        case (ext_mode_e'(i_mode))
            EXT_SEXT:   o_result = w_sext;
            EXT_ZEXT:   o_result = w_zext;
            EXT_UPPER:  o_result = w_upper;
            EXT_BRANCH: o_result = w_branch;
            default:    o_result = w_sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready handshake and 2-entry skid.
//
// state      | meaning
// -----------+---------------------------------------------------------
// SKID_EMPTY | nothing held; out_valid=0, in_ready=1
// SKID_ONE   | result in main register only; out_valid=1, in_ready=1
// SKID_TWO   | main and skid both full; out_valid=1, in_ready=0
//
// Results are extended at accept time, so both registers hold final
// OUT_W values and a skid-to-main move needs no recomputation.
// IN_W must be >= 2 and OUT_W >= IN_W+2.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_imm,
    input  logic [MODE_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_neg
);

    skid_state_e      r_state;
    skid_state_e      w_state_nxt;
    logic             r_in_ready;
    logic [OUT_W-1:0] r_main;
    logic [OUT_W-1:0] r_skid;
    logic [OUT_W-1:0] w_ext;
    logic             w_accept;
    logic             w_drain;
    logic             w_load_main_ext;
    logic             w_load_main_skid;
    logic             w_load_skid;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i_imm    (in_imm),
        .i_mode   (in_mode),
        .o_result (w_ext)
    );

    assign w_accept = in_valid && r_in_ready;
    assign w_drain  = (r_state != SKID_EMPTY) && out_ready;

    // Next occupancy and which register each new value lands in.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_ext  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_accept) begin
                    w_load_main_ext = 1'b1;
                    w_state_nxt     = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (w_accept && w_drain) begin
                    w_load_main_ext = 1'b1;
                end else if (w_accept) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = SKID_TWO;
                end else if (w_drain) begin
                    w_state_nxt = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                // in_ready is low here, so no accept can coincide.
                if (w_drain) begin
                    w_load_main_skid = 1'b1;
                    w_state_nxt      = SKID_ONE;
                end
            end
            default: begin
                w_state_nxt = SKID_EMPTY;
            end
        endcase
    end

    // Occupancy register; in_ready is registered from the next occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= SKID_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != SKID_TWO);
        end
    end

    // Data registers: main feeds the output, skid absorbs one stalled result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_ext) begin
                r_main <= w_ext;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_ext;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != SKID_EMPTY);
    assign out_data  = r_main;
    assign out_neg   = r_main[OUT_W-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: directed test-plan steps, then random traffic,
// all checked against an arithmetic FIFO model of the unit.
module tb_imm_extend_pipe;

    logic        clk;
    logic        reset;

    // Default instance, 16 -> 32.
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_neg;
    logic [15:0] a_in_imm;
    logic [1:0]  a_in_mode;
    logic [31:0] a_out_data;

    // Narrow instance, 12 -> 20.
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_neg;
    logic [11:0] b_in_imm;
    logic [1:0]  b_in_mode;
    logic [19:0] b_out_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_imm    (a_in_imm),
        .in_mode   (a_in_mode),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_neg   (a_out_neg)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(20)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_imm    (b_in_imm),
        .in_mode   (b_in_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_neg   (b_out_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Extension by plain integer arithmetic, reduced modulo 2**outw.
    function automatic longint ref_ext(input longint imm, input int mode,
                                       input int inw, input int outw);
        longint sval;
        longint r;
        longint half;
        half = longint'(1) << (inw - 1);
        sval = (imm >= half) ? imm - (longint'(1) << inw) : imm;
        case (mode)
            0:       r = sval;
            1:       r = imm;
            2:       r = imm * (longint'(1) << (outw - inw));
            default: r = sval * 4;
        endcase
        return r & ((longint'(1) << outw) - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle on instance A: check current outputs against the model,
    // apply inputs, clock, then update the model with what transferred.
    task automatic cyc(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                       input logic ordy);
        bit          acc;
        bit          drn;
        longint      e;
        logic [31:0] exp;
        chk("out_valid", {31'd0, a_out_valid}, {31'd0, q.size() != 0});
        chk("in_ready", {31'd0, a_in_ready}, {31'd0, q.size() < 2});
        if (q.size() != 0) begin
            chk("out_data", a_out_data, q[0]);
            chk("out_neg", {31'd0, a_out_neg}, {31'd0, q[0][31]});
        end
        a_in_valid  = v;
        a_in_imm    = imm;
        a_in_mode   = mode;
        a_out_ready = ordy;
        acc = v && (q.size() < 2);
        drn = ordy && (q.size() != 0);
        e   = ref_ext(longint'(imm), int'(mode), 16, 32);
        exp = e[31:0];
        @(posedge clk);
        #1;
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(exp);
    endtask

    initial begin
        logic [15:0] r_a;
        logic [15:0] r_b;
        a_in_valid = 0; a_in_imm = '0; a_in_mode = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_imm = '0; b_in_mode = '0; b_out_ready = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_out_data", a_out_data, 32'd0);
        chk("rst_out_neg", {31'd0, a_out_neg}, 32'd0);
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        reset = 1'b0;

        // Sign, zero, upper and branch extension, one cycle after accept.
        cyc(1, 16'h0005, 2'd0, 1);
        chk("sext_pos", a_out_data, 32'h0000_0005);
        chk("sext_pos_neg", {31'd0, a_out_neg}, 32'd0);
        cyc(1, 16'hFF85, 2'd0, 1);
        chk("sext_neg", a_out_data, 32'hFFFF_FF85);
        chk("sext_neg_neg", {31'd0, a_out_neg}, 32'd1);
        cyc(1, 16'hFF85, 2'd1, 1);
        chk("zext", a_out_data, 32'h0000_FF85);
        chk("zext_neg", {31'd0, a_out_neg}, 32'd0);
        cyc(1, 16'h1234, 2'd2, 1);
        chk("upper", a_out_data, 32'h1234_0000);
        cyc(1, 16'hFFFF, 2'd3, 1);
        chk("branch_neg", a_out_data, 32'hFFFF_FFFC);
        cyc(1, 16'h0010, 2'd3, 1);
        chk("branch_pos", a_out_data, 32'h0000_0040);
        cyc(0, 16'h0, 2'd0, 1);

        // Backpressure: 1 and 2 accepted, 3 held until space opens.
        cyc(1, 16'd1, 2'd0, 0);
        cyc(1, 16'd2, 2'd0, 0);
        chk("stall_ready_low", {31'd0, a_in_ready}, 32'd0);
        cyc(1, 16'd3, 2'd0, 0);
        chk("stall_hold_data", a_out_data, 32'd1);
        cyc(1, 16'd3, 2'd0, 1);
        chk("release_2", a_out_data, 32'd2);
        chk("release_ready", {31'd0, a_in_ready}, 32'd1);
        cyc(1, 16'd3, 2'd0, 1);
        chk("release_3", a_out_data, 32'd3);
        cyc(0, 16'h0, 2'd0, 1);

        // Back-to-back SEXT stream at full rate.
        for (int i = 0; i < 8; i++) begin
            cyc(1, 16'($urandom), 2'd0, 1);
            chk("b2b_ready", {31'd0, a_in_ready}, 32'd1);
            chk("b2b_valid", {31'd0, a_out_valid}, 32'd1);
        end
        cyc(0, 16'h0, 2'd0, 1);

        // Reset while the skid holds an entry.
        r_a = 16'($urandom);
        r_b = 16'($urandom);
        cyc(1, r_a, 2'd0, 0);
        cyc(1, r_b, 2'd1, 0);
        chk("pre_rst_full", {31'd0, a_in_ready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, a_in_ready}, 32'd1);
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(0, 16'h0, 2'd0, 1);

        // Random traffic under random backpressure.
        for (int i = 0; i < 400; i++) begin
            cyc(logic'($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom),
                logic'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++) cyc(0, 16'h0, 2'd1, 1);

        // Narrow instance: 12 -> 20.
        b_out_ready = 1;
        b_in_valid  = 1; b_in_imm = 12'h800; b_in_mode = 2'd0;
        @(posedge clk); #1;
        chk("n_sext", {12'd0, b_out_data}, 32'h000F_F800);
        chk("n_sext_neg", {31'd0, b_out_neg}, 32'd1);
        b_in_imm = 12'hABC; b_in_mode = 2'd2;
        @(posedge clk); #1;
        chk("n_upper", {12'd0, b_out_data}, 32'h000A_BC00);
        b_in_imm = 12'hFFF; b_in_mode = 2'd3;
        @(posedge clk); #1;
        chk("n_branch", {12'd0, b_out_data}, 32'(ref_ext(64'hFFF, 3, 12, 20)));
        chk("n_valid", {31'd0, b_out_valid}, 32'd1);
        b_in_valid = 0;
        @(posedge clk); #1;
        chk("n_drained", {31'd0, b_out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
